n163_irq_snd_regs: RTL
======================

Name: n163_irq_snd_regs

Overview:
- CPU-side register block for mapper 19 (Namco 163). It sits directly upstream of map_019 and feeds it, and map_019 in turn feeds map_hub.
- Implements the 15-bit CPU-cycle IRQ counter, the expansion-sound address port and the 128-byte internal sound RAM.
- Drives IRQ, read data and output-enable back into the mapper output bundle.

Parameters:
- RAM_AW, 7, sound RAM address width (128 bytes).
- CNT_W, 15, IRQ counter width.

Ports:
- clk  in  1  system clock; all state is clocked on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m2  in  1  CPU phi2, already synchronous to clk.
- cpu_addr  in  16  CPU address.
- cpu_dat  in  8  CPU write data.
- cpu_rw  in  1  1 = read, 0 = write.
- irq  out  1  IRQ request to the CPU, active high.
- dout  out  8  register or RAM read data.
- dout_oe  out  1  dout valid; drives the CPU data bus.
- snd_addr  out  7  current sound RAM address (for the audio engine).
- snd_rd_addr  in  7  audio engine RAM read address.
- snd_rd_dat  out  8  audio engine RAM read data, registered, 1 clk latency.

Behaviour:
- M2 edge detect:
  - m2_d registered each clk.
  - tick = m2_d & ~m2, i.e. one clk per CPU cycle at the M2 falling edge.
  - All CPU register writes and all counter steps commit on tick only.
- Reset values: cnt=0, en=0, irq=0, snd_addr=0, autoinc=0, dout=0, dout_oe=0, snd_rd_dat=0. RAM contents are not reset.
- Decode:
  - LO = 0x5000-0x57FF.
  - HI = 0x5800-0x5FFF.
  - DAT = 0x4800-0x4FFF.
  - ADR = 0xF800-0xFFFF.
- Writes (cpu_rw=0 at tick):
  - LO: cnt[7:0]=cpu_dat; irq cleared.
  - HI: cnt[14:8]=cpu_dat[6:0], en=cpu_dat[7]; irq cleared.
  - ADR: snd_addr=cpu_dat[6:0], autoinc=cpu_dat[7].
  - DAT: RAM[snd_addr]=cpu_dat, then post-increment.
- Reads:
  - dout_oe = m2 & cpu_rw & (LO|HI|DAT), combinational.
  - LO returns cnt[7:0].
  - HI returns {en, cnt[14:8]}.
  - DAT returns RAM[snd_addr].
  - ADR is write-only: dout_oe=0.
  - At the tick of a DAT read, post-increment.
- Post-increment: if autoinc=1, snd_addr = snd_addr+1 modulo 128 (0x7F wraps to 0x00); else unchanged.
- Counter step, on each tick:
  - Steps only when en=1 and cnt != 0x7FFF: cnt = cnt+1.
  - When the step produces 0x7FFF, irq is set in the same clk.
  - At 0x7FFF the counter holds; no further steps.
  - irq remains set while en=1 until a LO/HI write.
  - en=0 freezes cnt and leaves irq unchanged.
- Counter state machine: IDLE (en=0) -> COUNT (en=1, cnt<0x7FFF) -> FIRED (cnt=0x7FFF, irq=1) -> IDLE/COUNT on a LO/HI write.
- Simultaneous tick and LO/HI write: the write wins; no step in that CPU cycle.
- Writing cnt=0x7FFF with en=1 does not raise irq; irq sets only on a step into 0x7FFF.
- Reset mid-operation clears all registers immediately (async); the next tick after release behaves as after power-on.
- Audio port: snd_rd_dat <= RAM[snd_rd_addr] every clk.
  - CPU and audio accesses are independent (dual-read RAM).
  - Same-clk CPU write and audio read of the same address return the old data.

Optional Feature:
- Macro N163_RAM_EN.
- Defined: 128-byte sound RAM present as described above.
- Undefined:
  - No RAM is inferred.
  - DAT reads give dout_oe=0; DAT writes are ignored.
  - snd_addr and autoinc are still latched and post-incremented.
  - snd_rd_dat is tied to 0.

Test Plan:
- Reset, then write LO=0xFE, HI=0xFF (cnt=0x7FFE, en=1); one M2 cycle later -> irq=1, HI read returns 0xFF, LO read returns 0xFF; two further M2 cycles -> cnt still 0x7FFF, irq still 1.
- With irq=1, write HI=0x80 -> irq=0 at that tick, cnt=0x00FF, counting resumes; 0x7F00 M2 cycles later -> irq=1.
- Write LO=0x10 in the same M2 cycle in which a step would occur (en=1, cnt=0x0005) -> cnt=0x0010, not 0x0006.
- Write ADR=0xFE, DAT=0x11, DAT=0x22, DAT=0x33 -> RAM[0x7E]=0x11, RAM[0x7F]=0x22, RAM[0x00]=0x33, snd_addr=0x01; write ADR=0x7E, read DAT twice -> 0x11, 0x11 (no autoinc).
- Assert rst_n=0 mid-count with irq=1 -> irq=0, cnt=0, en=0 without waiting for a clk edge; M2 ticks after release -> cnt stays 0.
- Build without N163_RAM_EN: DAT read -> dout_oe=0; ADR=0x85 then DAT write -> snd_addr=0x06, snd_rd_dat=0.

Source files
------------

// File: rtl/n163_irq_snd_regs.sv
// ---------------------------------------------------------------------------
// n163_irq_snd_regs
//
// Purpose:
//   CPU-side register block for the Namco 163 mapper (mapper 19). It holds
//   the 15-bit CPU-cycle IRQ counter, the expansion-sound address port and,
//   optionally, the 128-byte internal sound RAM. It returns IRQ, read data
//   and the read output-enable to the mapper output bundle.
//
// Optional feature macro: N163_RAM_EN
//   Defined   : the 128-byte sound RAM is built. DAT accesses read and write
//               it, and the audio engine reads it through snd_rd_addr.
//   Undefined : no RAM is built. DAT reads are not driven (dout_oe=0), DAT
//               writes are dropped, and snd_rd_dat is tied to 0. The sound
//               address register and its auto-increment still work.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   m2          in   CPU phi2, already synchronous to clk
//   cpu_addr    in   CPU address [15:0]
//   cpu_dat     in   CPU write data [7:0]
//   cpu_rw      in   1 = read, 0 = write
//   irq         out  IRQ request, active high
//   dout        out  register / RAM read data (registered)
//   dout_oe     out  dout valid, drives the CPU data bus (combinational)
//   snd_addr    out  current sound RAM address
//   snd_rd_addr in   audio engine RAM read address
//   snd_rd_dat  out  audio engine RAM read data, 1 clk latency
//
// Register map (decoded on cpu_addr[15:11]):
//   0x4800-0x4FFF DAT   sound RAM data port, post-increment
//   0x5000-0x57FF LO    counter bits [7:0]
//   0x5800-0x5FFF HI    {enable, counter bits [14:8]}
//   0xF800-0xFFFF ADR   {autoinc, sound address}, write-only
// ---------------------------------------------------------------------------
module n163_irq_snd_regs #(
   parameter int RAM_AW = 7,
   parameter int CNT_W  = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m2,
   input  logic [15:0]       cpu_addr,
   input  logic [7:0]        cpu_dat,
   input  logic              cpu_rw,
   output logic              irq,
   output logic [7:0]        dout,
   output logic              dout_oe,
   output logic [RAM_AW-1:0] snd_addr,
   input  logic [RAM_AW-1:0] snd_rd_addr,
   output logic [7:0]        snd_rd_dat
);

   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [RAM_AW-1:0] ADDR_ONE = {{(RAM_AW-1){1'b0}}, 1'b1};

   // Counter FSM. IDLE: disabled. COUNT: enabled, stepping unless the
   // counter was loaded with the terminal value directly. FIRED: the counter
   // stepped into the terminal value; this state alone drives irq.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_FIRED = 2'd2
   } cnt_state_t;

   cnt_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              en_q, en_d;
   logic [RAM_AW-1:0] snd_addr_q, snd_addr_d;
   logic              autoinc_q, autoinc_d;
   logic [7:0]        dout_q, dout_d;
   logic              m2_q;

   logic tick;
   logic sel_lo, sel_hi, sel_dat, sel_adr;
   logic wr_lo, wr_hi, wr_adr, wr_dat;
   logic acc_dat;
   logic step_ok;
   logic dat_oe;
   logic [7:0] ram_rd_q;

   // Address bits below the 2 KiB decode granularity are not used here.
   logic unused_in;
   assign unused_in = ^{cpu_addr[10:0], snd_rd_addr};

   // ------------------------------------------------------------------
   // M2 falling-edge detect: one clk per CPU cycle, at the end of phi2.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m2_q <= 1'b0;
      end else begin
         m2_q <= m2;
      end
   end

   assign tick = m2_q & ~m2;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   assign sel_dat = (cpu_addr[15:11] == 5'b01001);
   assign sel_lo  = (cpu_addr[15:11] == 5'b01010);
   assign sel_hi  = (cpu_addr[15:11] == 5'b01011);
   assign sel_adr = (cpu_addr[15:11] == 5'b11111);

   assign wr_lo   = tick & ~cpu_rw & sel_lo;
   assign wr_hi   = tick & ~cpu_rw & sel_hi;
   assign wr_adr  = tick & ~cpu_rw & sel_adr;
   assign wr_dat  = tick & ~cpu_rw & sel_dat;
   // Either direction of DAT access advances the address pointer.
   assign acc_dat = tick & sel_dat;

   // A counter loaded with the terminal value while enabled sits in COUNT
   // but must not step (and so never raises irq).
   assign step_ok = (state_q == ST_COUNT) && (cnt_q != CNT_MAX);

`ifdef N163_RAM_EN
   assign dat_oe = sel_dat;
`else
   assign dat_oe = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      cnt_d      = cnt_q;
      en_d       = en_q;
      state_d    = state_q;
      snd_addr_d = snd_addr_q;
      autoinc_d  = autoinc_q;
      dout_d     = 8'h00;

      // A LO/HI write takes priority over the step of the same CPU cycle.
      if (wr_lo) begin
         cnt_d[7:0] = cpu_dat;
      end else if (wr_hi) begin
         cnt_d[14:8] = cpu_dat[6:0];
         en_d        = cpu_dat[7];
      end else if (tick && step_ok) begin
         cnt_d = cnt_q + CNT_ONE;
      end

      case (state_q)
         ST_IDLE: begin
            if (wr_lo || wr_hi) begin
               state_d = en_d ? ST_COUNT : ST_IDLE;
            end
         end
         ST_COUNT: begin
            if (wr_lo || wr_hi) begin
               state_d = en_d ? ST_COUNT : ST_IDLE;
            end else if (tick && step_ok && (cnt_d == CNT_MAX)) begin
               state_d = ST_FIRED;
            end
         end
         ST_FIRED: begin
            if (wr_lo || wr_hi) begin
               state_d = en_d ? ST_COUNT : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (wr_adr) begin
         snd_addr_d = cpu_dat[6:0];
         autoinc_d  = cpu_dat[7];
      end else if (acc_dat && autoinc_q) begin
         snd_addr_d = snd_addr_q + ADDR_ONE;
      end

      // Read data is captured every clk while the CPU drives a read.
      if (m2 && cpu_rw) begin
         if (sel_lo) begin
            dout_d = cnt_q[7:0];
         end else if (sel_hi) begin
            dout_d = {en_q, cnt_q[14:8]};
         end else if (dat_oe) begin
            dout_d = ram_rd_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         en_q       <= 1'b0;
         snd_addr_q <= '0;
         autoinc_q  <= 1'b0;
         dout_q     <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         en_q       <= en_d;
         snd_addr_q <= snd_addr_d;
         autoinc_q  <= autoinc_d;
         dout_q     <= dout_d;
      end
   end

   // ------------------------------------------------------------------
   // Sound RAM
   // ------------------------------------------------------------------
`ifdef N163_RAM_EN
   logic [7:0] ram [0:(1<<RAM_AW)-1];
   logic [7:0] snd_rd_dat_q;

   // CPU port: write at the tick, registered read of the current pointer.
   // A same-clk write and read of one address returns the old byte.
   always_ff @(posedge clk) begin
      if (wr_dat) begin
         ram[snd_addr_q] <= cpu_dat;
      end
      ram_rd_q <= ram[snd_addr_q];
   end

   // Audio port: independent registered read every clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snd_rd_dat_q <= 8'h00;
      end else begin
         snd_rd_dat_q <= ram[snd_rd_addr];
      end
   end

   assign snd_rd_dat = snd_rd_dat_q;
`else
   logic unused_wr;
   assign unused_wr  = wr_dat;
   assign ram_rd_q   = 8'h00;
   assign snd_rd_dat = 8'h00;
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign irq      = (state_q == ST_FIRED);
   assign dout     = dout_q;
   assign dout_oe  = m2 & cpu_rw & (sel_lo | sel_hi | dat_oe);
   assign snd_addr = snd_addr_q;

endmodule
